// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// Instruction-memory loader: unpacks a framed byte stream (count, 4*N data bytes,
// XOR checksum) into 32-bit words and holds the CPU in reset until a good load.
module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   last_q, last_d;
  logic [ADDR_WIDTH-1:0]   widx_q, widx_d;
  logic [1:0]              bidx_q, bidx_d;
  logic [7:0]              csum_q, csum_d;
  logic [23:0]             asm_q, asm_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic       accept;
  logic [8:0] n_ext;
  logic       too_big;

  assign in_ready = !reset && (state_q inside {S_IDLE, S_LOAD, S_CHECK});
  assign accept   = in_valid && in_ready;

  // A count byte of zero stands for a full memory of DEPTH words.
  assign n_ext   = (in_data == 8'd0) ? 9'(DEPTH) : {1'b0, in_data};
  assign too_big = n_ext > 9'(DEPTH);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    widx_d      = widx_q;
    bidx_d      = bidx_q;
    csum_d      = csum_q;
    asm_d       = asm_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    if (reload) begin
      state_d     = S_IDLE;
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
      error_d     = 1'b0;
      widx_d      = '0;
      bidx_d      = '0;
      csum_d      = '0;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (too_big) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            last_d  = ADDR_WIDTH'(n_ext - 9'd1);
            widx_d  = '0;
            bidx_d  = '0;
            csum_d  = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          csum_d = csum_q ^ in_data;
          asm_d  = {asm_q[15:0], in_data};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q;
            wdata_d = {asm_q, in_data};
            widx_d  = widx_q + ADDR_WIDTH'(1);
            if (widx_q == last_q) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (in_data == csum_q) begin
            state_d     = S_RUN;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= '0;
      widx_q      <= '0;
      bidx_q      <= '0;
      csum_q      <= '0;
      asm_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      csum_q      <= csum_d;
      asm_q       <= asm_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
